// File: rtl/rom_loader.sv
// rom_loader: streams a length-prefixed ROM image from the UART byte receiver into SRAM.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing 8-bit payload checksum byte.
module rom_loader #(
  parameter int ADDR_WIDTH  = 19,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clockgb,
  input  logic                  resetn,
  input  logic                  prog,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [7:0]            wr_data,
  output logic                  wr_req,
  input  logic                  wr_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam logic [24:0] MAX_LEN     = 25'd1 << ADDR_WIDTH;
  localparam logic [7:0]  TMO_LIMIT   = 8'(ACK_TIMEOUT);
  localparam logic [1:0]  ERR_OVERRUN = 2'd1;
  localparam logic [1:0]  ERR_LENGTH  = 2'd2;
  localparam logic [1:0]  ERR_CHECK   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LEN0  = 4'd1,
    S_LEN1  = 4'd2,
    S_LEN2  = 4'd3,
    S_DATA  = 4'd4,
    S_WRITE = 4'd5,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CSUM  = 4'd6,
`endif
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  state_t                  state_q, state_d;
  logic                    prog_q;
  logic [23:0]             len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    req_q, req_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [1:0]              code_q, code_d;
  logic [7:0]              tmo_q, tmo_d;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  logic [23:0] len_full;
  logic        len_bad;
  logic [24:0] next_count;

  // The third length byte is checked in the same cycle it arrives.
  assign len_full   = {rx_data, len_q[15:0]};
  assign len_bad    = (len_full == 24'd0) || ({1'b0, len_full} > MAX_LEN);
  assign next_count = 25'(addr_q) + 25'd1;

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign wr_address = addr_q;
  assign wr_data    = data_q;
  assign wr_req     = req_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = code_q;

  // Next-state and registered-output logic of the frame FSM.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    tmo_d   = tmo_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (!prog) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b0;
      code_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!prog_q) begin
            state_d = S_LEN0;
            len_d   = 24'd0;
            addr_d  = '0;
            tmo_d   = 8'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_d   = 8'd0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LEN0: begin
          if (rx_valid) begin
            len_d[7:0] = rx_data;
            state_d    = S_LEN1;
          end else begin
            state_d = S_LEN0;
          end
        end
        S_LEN1: begin
          if (rx_valid) begin
            len_d[15:8] = rx_data;
            state_d     = S_LEN2;
          end else begin
            state_d = S_LEN1;
          end
        end
        S_LEN2: begin
          if (rx_valid && len_bad) begin
            len_d   = len_full;
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = ERR_LENGTH;
          end else if (rx_valid) begin
            len_d   = len_full;
            state_d = S_DATA;
          end else begin
            state_d = S_LEN2;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            data_d  = rx_data;
            req_d   = 1'b1;
            tmo_d   = 8'd0;
            state_d = S_WRITE;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_d   = sum_q + rx_data;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
        S_WRITE: begin
          // A new byte beats the ack: the UART outran the SRAM even if the ack lands now.
          if (rx_valid) begin
            req_d   = 1'b0;
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = ERR_OVERRUN;
          end else if (wr_ack) begin
            req_d  = 1'b0;
            addr_d = addr_q + 1'b1;
            if (next_count == {1'b0, len_q}) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = S_DATA;
            end
          end else if ((tmo_q + 8'd1) == TMO_LIMIT) begin
            tmo_d   = tmo_q + 8'd1;
            req_d   = 1'b0;
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = ERR_CHECK;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_valid && (rx_data == sum_q)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (rx_valid) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = ERR_CHECK;
          end else begin
            state_d = S_CSUM;
          end
        end
`endif
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      prog_q  <= 1'b0;
      len_q   <= 24'd0;
      addr_q  <= '0;
      data_q  <= 8'd0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= 2'd0;
      tmo_q   <= 8'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      prog_q  <= prog;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      tmo_q   <= tmo_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed and randomized frames against a frame-level model.
// The model follows ROM_LOADER_CHECKSUM_EN the same way the design build does.
module tb_rom_loader;
  localparam int AW = 19;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clockgb = 1'b0;
  logic          resetn = 1'b0;
  logic          prog = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] wr_address;
  logic [7:0]    wr_data;
  logic          wr_req;
  logic          wr_ack = 1'b0;
  logic          busy, done, error;
  logic [1:0]    err_code;

  int n_cmp = 0;
  int n_bad = 0;
  bit ack_en = 1'b1;
  int ack_delay = 1;
  int wait_cnt = 0;
  bit req_seen = 1'b0;
  logic [AW-1:0] wq_addr[$];
  logic [7:0]    wq_data[$];

  rom_loader dut (
    .clockgb(clockgb), .resetn(resetn), .prog(prog), .rx_data(rx_data),
    .rx_valid(rx_valid), .wr_address(wr_address), .wr_data(wr_data),
    .wr_req(wr_req), .wr_ack(wr_ack), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clockgb = ~clockgb;

  // SRAM model: acks a pending request after ack_delay cycles and records the write.
  always @(negedge clockgb) begin
    if (wr_req) req_seen = 1'b1;
    if (wr_ack) begin
      wr_ack = 1'b0;
      wait_cnt = 0;
    end else if (wr_req && ack_en) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        wr_ack = 1'b1;
        wq_addr.push_back(wr_address);
        wq_data.push_back(wr_data);
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clockgb);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_write(input string tag);
    int k = 0;
    while (wr_req && k < 50) begin
      tick();
      k++;
    end
    if (wr_req) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_ack_wait: wr_req got 1 want 0 within 50 cycles", tag);
    end
  endtask

  task automatic start_frame();
    wq_addr.delete();
    wq_data.delete();
    req_seen = 1'b0;
    prog = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    prog = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_header(input logic [23:0] len);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    send_byte(len[23:16]);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] pl[$], input logic [7:0] csum, input int dly);
    logic [7:0] sum = 8'd0;
    bit exp_done;
    ack_delay = dly;
    ack_en = 1'b1;
    start_frame();
    send_header(24'(pl.size()));
    foreach (pl[i]) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(pl[i]);
      wait_write(tag);
      sum = sum + pl[i];
    end
    send_byte(csum);
    tick();
    exp_done = !CSUM_EN || (csum == sum);
    n_cmp++;
    if (wq_addr.size() !== pl.size()) begin
      n_bad++;
      $display("FAIL %s_nwrites: got %0d want %0d", tag, wq_addr.size(), pl.size());
    end
    for (int i = 0; i < pl.size() && i < wq_addr.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== pl[i]) begin
        n_bad++;
        $display("FAIL %s_write%0d: got %0h@%0h want %0h@%0h", tag, i, wq_data[i], wq_addr[i], pl[i], i);
      end
    end
    n_cmp++;
    if (done !== exp_done || error !== !exp_done || err_code !== (exp_done ? 2'd0 : 2'd3) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_status: got done=%b err=%b code=%0d busy=%b want done=%b err=%b code=%0d busy=0",
               tag, done, error, err_code, busy, exp_done, !exp_done, exp_done ? 0 : 3);
    end
    end_frame();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (wr_req !== 1'b0 || wr_address !== '0 || wr_data !== 8'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_datapath: got req=%b addr=%0h data=%0h busy=%b want all 0", wr_req, wr_address, wr_data, busy);
    end
    n_cmp++;
    if (done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_status: got done=%b err=%b code=%0d want 0 0 0", done, error, err_code);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] pl[$];
    pl = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("good_csum", pl, 8'hAA, 1);
    run_frame("bad_csum", pl, 8'h00, 1);
  endtask

  task automatic test_length();
    start_frame();
    send_header(24'h000000);
    tick();
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd2 || req_seen !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL len_zero: got err=%b code=%0d req_seen=%b busy=%b want 1 2 0 0", error, err_code, req_seen, busy);
    end
    end_frame();
    start_frame();
    send_header(24'h080001);
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd2) begin
      n_bad++;
      $display("FAIL len_over: got err=%b code=%0d want 1 2", error, err_code);
    end
    end_frame();
    start_frame();
    send_header(24'h080000);
    n_cmp++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL len_max: got err=%b busy=%b want 0 1", error, busy);
    end
    end_frame();
  endtask

  task automatic test_overrun();
    ack_en = 1'b0;
    start_frame();
    send_header(24'd4);
    send_byte(8'h5A);
    n_cmp++;
    if (wr_req !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_req: got %b want 1", wr_req);
    end
    send_byte(8'hA5);
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd1 || wr_req !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun: got err=%b code=%0d req=%b want 1 1 0", error, err_code, wr_req);
    end
    end_frame();
    ack_en = 1'b1;
    ack_delay = 2;
    start_frame();
    send_header(24'd4);
    send_byte(8'h01);
    tick();
    send_byte(8'h02);
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd1 || wr_req !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_with_ack: got err=%b code=%0d req=%b want 1 1 0", error, err_code, wr_req);
    end
    end_frame();
    ack_delay = 1;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    ack_en = 1'b0;
    start_frame();
    send_header(24'd2);
    send_byte(8'h77);
    while (wr_req && error === 1'b0 && cnt < 400) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 255) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d want 255", cnt);
    end
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd3 || wr_req !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout: got err=%b code=%0d req=%b want 1 3 0", error, err_code, wr_req);
    end
    end_frame();
    ack_en = 1'b1;
  endtask

  task automatic test_prog_drop();
    logic [7:0] pl[$];
    pl = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    ack_en = 1'b1;
    ack_delay = 1;
    start_frame();
    send_header(24'd4);
    for (int i = 0; i < 2; i++) begin
      send_byte(pl[i]);
      wait_write("drop");
    end
    ack_en = 1'b0;
    send_byte(pl[2]);
    prog = 1'b0;
    tick();
    n_cmp++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || wq_addr.size() !== 2) begin
      n_bad++;
      $display("FAIL prog_drop: got req=%b busy=%b done=%b err=%b writes=%0d want 0 0 0 0 2",
               wr_req, busy, done, error, wq_addr.size());
    end
    ack_en = 1'b1;
    tick();
    run_frame("reload", pl, 8'h0A, 1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      logic [7:0] pl[$];
      logic [7:0] sum = 8'd0;
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        pl.push_back(8'($urandom));
        sum = sum + pl[i];
      end
      run_frame($sformatf("rand%0d", f), pl, ($urandom_range(0, 1) == 0) ? sum : 8'($urandom), $urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_length();
    test_overrun();
    test_timeout();
    test_prog_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
